// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte at a time and sends it as 8N1,
// or 8E1 when the TX_PARITY_EN macro is defined.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_en_i,
  input  logic        fifo_empty_i,
  input  logic [7:0]  fifo_data_i,
  output logic        fifo_pop_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic [15:0] bytes_sent_o
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } state_e;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_d;
  logic              baud_last_s;
  logic [2:0]        bit_q;
  logic [7:0]        shreg_q;
`ifdef TX_PARITY_EN
  logic              parity_q;
`endif
  logic              fifo_pop_q;
  logic              tx_q;
  logic              busy_q;
  logic [15:0]       bytes_q;

  // Baud counter next value: wraps to zero on every bit boundary.
  always_comb begin
    baud_last_s = (baud_q == BAUD_LAST);
    if (baud_last_s) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end
  end

  // Transmit FSM; tx_q always carries the level of the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'h00;
`ifdef TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
      fifo_pop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      bytes_q    <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (tx_en_i && !fifo_empty_i) begin
            state_q    <= ST_POP;
            fifo_pop_q <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            fifo_pop_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        ST_POP: begin
          fifo_pop_q <= 1'b0;
          state_q    <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg_q  <= fifo_data_i;
`ifdef TX_PARITY_EN
          parity_q <= even_parity(fifo_data_i);
`endif
          bit_q    <= 3'd0;
          baud_q   <= '0;
          tx_q     <= 1'b0;
          state_q  <= ST_START;
        end
        ST_START: begin
          baud_q <= baud_d;
          if (baud_last_s) begin
            state_q <= ST_DATA;
            tx_q    <= shreg_q[0];
          end
        end
        ST_DATA: begin
          baud_q <= baud_d;
          if (baud_last_s) begin
            shreg_q <= {1'b0, shreg_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef TX_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              tx_q <= shreg_q[1];
            end
          end
        end
`ifdef TX_PARITY_EN
        ST_PARITY: begin
          baud_q <= baud_d;
          if (baud_last_s) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          baud_q <= baud_d;
          tx_q   <= 1'b1;
          if (baud_last_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            bytes_q <= bytes_q + 16'd1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          fifo_pop_q <= 1'b0;
          tx_q       <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_pop_o   = fifo_pop_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign bytes_sent_o = bytes_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the 8-bit synchronous FIFO and shifts each byte out as an asynchronous 8N1 frame (8E1 with parity compiled in). It sits directly downstream of the FIFO: it watches the FIFO's `empty` flag, issues single-cycle `pop` pulses, captures the FIFO's registered `data_out`, and drives the serial line. It is the only consumer of the FIFO's pop port.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2..65535.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `tx_en` input 1: permission to start a new frame. A frame already in progress always completes.
- `fifo_empty` input 1: connects to FIFO `empty`.
- `fifo_data` input 8: connects to FIFO `data_out`. It is valid the cycle after `fifo_pop`.
- `fifo_pop` output 1: connects to FIFO `pop`. Registered, one-cycle pulse.
- `tx` output 1: serial line. Idle level is high.
- `busy` output 1: high in every state except IDLE.
- `bytes_sent` output 16: count of completed frames. Wraps from 0xFFFF to 0x0000.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY (only when `TX_PARITY_EN` is defined), STOP.
- IDLE:
  - `tx`=1.
  - Go to POP when `tx_en`=1 and `fifo_empty`=0.
- POP:
  - `fifo_pop`=1 for this single cycle.
  - Go unconditionally to LOAD.
- LOAD:
  - Capture `fifo_data` into the 8-bit shift register.
  - Clear the bit index and the baud counter.
  - Go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0 (LSB first).
  - After each `CLKS_PER_BIT` cycles, shift right and increment the bit index.
  - After bit 7, go to PARITY if enabled, otherwise STOP.
- PARITY: `tx` = XOR of the 8 captured bits (even parity) for `CLKS_PER_BIT` cycles.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - On the last cycle, increment `bytes_sent` and go to IDLE.
- Baud counter:
  - Width is ceil(log2(`CLKS_PER_BIT`)).
  - Counts 0..`CLKS_PER_BIT`-1 and resets to 0 on each bit boundary.
- `tx_en` is sampled only in IDLE. Deasserting it mid-frame has no effect on that frame.
- `fifo_empty` is sampled only in IDLE. This block is the only popper, so `empty` cannot assert between IDLE and POP.
- The block never pops an empty FIFO. `fifo_pop` is asserted only in the POP state.

## Timing
- Reset values: `fifo_pop`=0, `tx`=1, `busy`=0, `bytes_sent`=0. State is IDLE and the shift register is 0.
- Reset mid-frame:
  - On the next edge, `tx`=1 and the state returns to IDLE.
  - The byte in flight is lost and is not counted.
  - The FIFO itself is reset by the same `rst`.
- Let c be the IDLE cycle in which the start condition holds:
  - `fifo_pop` is high in cycle c+1.
  - Capture happens at c+2.
  - The start bit begins at c+3.
- Frame length is F = 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- The last STOP cycle is c+2+F. The block returns to IDLE at c+3+F.
- Back-to-back with a non-empty FIFO: pop-to-pop spacing is F+3 cycles. Between frames, `tx` is high for 3 cycles (IDLE, POP, LOAD) beyond the stop bit.
- `busy` rises in cycle c+1 and falls in cycle c+3+F.
- `bytes_sent` updates on the edge that leaves STOP, so it is visible in cycle c+3+F.

## Configuration
- `TX_PARITY_EN`, when defined:
  - The PARITY state exists and an even-parity bit is inserted between data bit 7 and stop.
  - F = 11×`CLKS_PER_BIT`.
- When undefined:
  - The PARITY state and its logic are absent and frames are 8N1.
  - F = 10×`CLKS_PER_BIT`.

## Test plan
- **Reset and idle.** Assert `rst` for 2 cycles with the FIFO empty, then release and wait 50 cycles.
  - Expect `tx`=1, `fifo_pop`=0, `busy`=0 and `bytes_sent`=0 throughout.
- **Single byte.** Use `CLKS_PER_BIT`=4, no parity, and push 0xF0 into the FIFO.
  - Expect exactly one pop.
  - Expect `tx` sequence 0, then 0,0,0,0,1,1,1,1 (LSB first), then 1, with each level held 4 cycles.
  - Expect `bytes_sent`=1 and `empty`=1 afterwards.
- **Back-to-back drain.** Push 0xFF, 0xF0, 0xFA, 0xAA, 0xF1, 0x0F, 0xF5, 0x05 until `full`=1, then set `tx_en`=1.
  - Expect 8 frames in push order.
  - Expect pop-to-pop spacing of 43 cycles and `bytes_sent`=8 at the end.
- **tx_en gating.** Hold `tx_en`=0 with 3 bytes queued.
  - Expect no pop and `tx`=1.
  - Drop `tx_en` during the DATA bits of frame 1: frame 1 completes and no second pop occurs until `tx_en` returns to 1.
- **Reset mid-frame.** Assert `rst` during data bit 3 of 0xAA.
  - On the next edge expect `tx`=1 and `busy`=0, with `bytes_sent` remaining 0.
  - A subsequent push of 0x55 transmits cleanly.
- **Parity build (`TX_PARITY_EN`).**
  - For 0x0F (even number of ones), expect parity bit 0.
  - For 0x07, expect parity bit 1.
  - Expect pop-to-pop spacing of 47 cycles at `CLKS_PER_BIT`=4.
